// File: rtl/aes_uart_pkg.sv
// Shared definitions for the host-to-AES UART receive path.
//   rx_state_t      : byte receiver FSM states
//   AES_BLOCK_BYTES : bytes per 128-bit AES word
//   FRAME_BYTES     : bytes per frame (plaintext followed by key)
//   clks_per_bit()  : system clocks per UART bit (integer division)
package aes_uart_pkg;

   localparam int unsigned AES_BLOCK_BYTES = 16;
   localparam int unsigned FRAME_BYTES     = 2 * AES_BLOCK_BYTES;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop input synchroniser plus byte FSM.
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   rx         : asynchronous serial input, idle high
//   byte_data  : last received data byte (valid while byte_valid is high)
//   byte_valid : one-cycle pulse, byte received with a good stop bit
//   stop_err   : one-cycle pulse, stop bit sampled low (byte dropped)
//   idle       : FSM is waiting for a start bit
module uart_rx_byte
   import aes_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       stop_err,
   output logic       idle
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_meta;
   logic             rx_s;
   rx_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       data_n;
   logic             byte_valid_n;
   logic             stop_err_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_s       <= rx_meta;
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         byte_data  <= data_n;
         byte_valid <= byte_valid_n;
         stop_err   <= stop_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      bit_idx_n    = bit_idx;
      data_n       = byte_data;
      byte_valid_n = 1'b0;
      stop_err_n   = 1'b0;
      unique case (state)
         RX_IDLE: begin
            if (!rx_s) begin
               state_n = RX_START;
               cnt_n   = '0;
            end
         end
         // Re-check the start bit at mid-bit; every later sample then lands
         // in the middle of its bit because DATA/STOP count full bit periods.
         RX_START: begin
            if (cnt == HALF) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == LAST) begin
               cnt_n  = '0;
               data_n = {rx_s, byte_data[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = RX_STOP;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  byte_valid_n = 1'b1;
                  state_n      = RX_IDLE;
               end else begin
                  stop_err_n = 1'b1;
                  state_n    = RX_WAIT_IDLE;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_s) begin
               state_n = RX_IDLE;
            end
         end
         default: begin
            state_n = RX_IDLE;
         end
      endcase
   end

   assign idle = (state == RX_IDLE);

endmodule

// File: rtl/aes_block_uart_rx.sv
// UART receive front end for the AES datapath. Collects 32 bytes
// (16 B plaintext then 16 B key) and presents both 128-bit words.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low
//   rx          : asynchronous serial input, idle high
//   plaintext   : last complete plaintext, byte 0 in [127:120]
//   key         : last complete key, byte 16 in [127:120]
//   block_valid : one-cycle pulse when plaintext/key update
//   frame_err   : sticky stop-bit error, cleared by a completed frame
//   byte_count  : bytes accepted in the current frame, 0..31
module aes_block_uart_rx
   import aes_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned BAUD         = 115_200,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rx,
   output logic [127:0] plaintext,
   output logic [127:0] key,
   output logic         block_valid,
   output logic         frame_err,
   output logic [5:0]   byte_count
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
   localparam int unsigned TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CLKS);
   localparam int unsigned FRAME_BITS   = 8 * FRAME_BYTES;
   localparam int unsigned BLOCK_BITS   = 8 * AES_BLOCK_BYTES;
   localparam logic [5:0]  LAST_BYTE    = 6'(FRAME_BYTES - 1);

   logic [7:0]            byte_data;
   logic                  byte_valid;
   logic                  stop_err;
   logic                  idle;
   // Only 31 bytes are ever held; the 32nd joins straight from byte_data
   // in the cycle the frame completes.
   logic [FRAME_BITS-9:0] shift_q;
   logic [FRAME_BITS-1:0] frame_n;
   logic [TO_W-1:0]       to_cnt;
   logic                  timeout_hit;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_byte (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .stop_err  (stop_err),
      .idle      (idle)
   );

   assign frame_n     = {shift_q, byte_data};
   assign timeout_hit = idle && (byte_count != '0) && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         shift_q     <= '0;
         plaintext   <= '0;
         key         <= '0;
         block_valid <= 1'b0;
         frame_err   <= 1'b0;
         byte_count  <= '0;
         to_cnt      <= '0;
      end else begin
         block_valid <= 1'b0;
         // A byte arriving on the timeout cycle wins: it is checked first.
         if (byte_valid) begin
            shift_q <= frame_n[FRAME_BITS-9:0];
            if (byte_count == LAST_BYTE) begin
               plaintext   <= frame_n[FRAME_BITS-1:BLOCK_BITS];
               key         <= frame_n[BLOCK_BITS-1:0];
               block_valid <= 1'b1;
               frame_err   <= 1'b0;
               byte_count  <= '0;
            end else begin
               byte_count <= byte_count + 1'b1;
            end
         end else if (stop_err) begin
            frame_err  <= 1'b1;
            byte_count <= '0;
         end else if (timeout_hit) begin
            byte_count <= '0;
         end

         if (!idle || byte_valid || (byte_count == '0)) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_block_uart_rx.sv
// Self-checking bench for aes_block_uart_rx at 10 clocks per bit.
module tb_aes_block_uart_rx;

   localparam int unsigned CPB          = 10;
   localparam int unsigned TIMEOUT_CLKS = 4 * CPB;
   localparam int unsigned BYTE_CLKS    = 10 * CPB;

   logic         clk = 1'b0;
   logic         reset;
   logic         rx;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         block_valid;
   logic         frame_err;
   logic [5:0]   byte_count;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   int unsigned  cyc = 0;

   // Reference model: bytes of the open frame, expected outputs, pulse times.
   logic [7:0]   m_bytes[$];
   logic [127:0] m_plain = '0;
   logic [127:0] m_key = '0;
   logic         m_err = 1'b0;
   int unsigned  exp_q[$];
   int unsigned  obs_q[$];

   aes_block_uart_rx #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD        (100_000),
      .TIMEOUT_BITS(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .plaintext  (plaintext),
      .key        (key),
      .block_valid(block_valid),
      .frame_err  (frame_err),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (block_valid) obs_q.push_back(cyc);
   end

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serialises one 8N1 byte and updates the model. Called 1 ns after a
   // rising edge; returns 1 ns after the edge ending the stop bit.
   task automatic send_byte(input logic [7:0] b, input logic good_stop);
      int unsigned e0;
      e0 = cyc;
      rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cycles(CPB);
      end
      rx = good_stop;
      cycles(CPB);
      rx = 1'b1;
      if (good_stop) begin
         m_bytes.push_back(b);
         if (m_bytes.size() == 32) begin
            for (int i = 0; i < 16; i++) begin
               m_plain = {m_plain[119:0], m_bytes[i]};
               m_key   = {m_key[119:0], m_bytes[16 + i]};
            end
            m_err = 1'b0;
            m_bytes.delete();
            exp_q.push_back(e0 + BYTE_CLKS);
         end
      end else begin
         m_err = 1'b1;
         m_bytes.delete();
         cycles(2 * CPB);
      end
   endtask

   task automatic send_random(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) send_byte(8'($urandom), 1'b1);
   endtask

   task automatic idle_gap(input int unsigned n);
      cycles(n);
      if (n >= TIMEOUT_CLKS + 8) m_bytes.delete();
   endtask

   task automatic test_reset;
      reset = 1'b0;
      rx    = 1'b1;
      cycles(4);
      checks++;
      if (plaintext !== '0 || key !== '0) begin
         errors++;
         $display("FAIL reset_data: pt=%h key=%h expected 0", plaintext, key);
      end
      checks++;
      if (block_valid !== 1'b0 || frame_err !== 1'b0 || byte_count !== 6'd0) begin
         errors++;
         $display("FAIL reset_flags: bv=%b fe=%b bc=%0d expected 0 0 0",
                  block_valid, frame_err, byte_count);
      end
      reset = 1'b1;
      cycles(3);
   endtask

   task automatic test_known_vector;
      logic [255:0] frame;
      frame = 256'h0123456789abcdeffedcba98765432100f1571c947d9e8590cb7add6af7f6798;
      for (int i = 31; i >= 0; i--) send_byte(frame[8*i +: 8], 1'b1);
      cycles(3);
      checks++;
      if (plaintext !== 128'h0123456789abcdeffedcba9876543210) begin
         errors++;
         $display("FAIL kv_plaintext: got %h expected 0123456789abcdeffedcba9876543210", plaintext);
      end
      checks++;
      if (key !== 128'h0f1571c947d9e8590cb7add6af7f6798) begin
         errors++;
         $display("FAIL kv_key: got %h expected 0f1571c947d9e8590cb7add6af7f6798", key);
      end
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL kv_pulses: got %0d pulses expected 1", obs_q.size());
      end else if (obs_q[0] != exp_q[0]) begin
         errors++;
         $display("FAIL kv_latency: pulse at cycle %0d expected %0d", obs_q[0], exp_q[0]);
      end
      checks++;
      if (byte_count !== 6'd0) begin
         errors++;
         $display("FAIL kv_count: got %0d expected 0", byte_count);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_glitch;
      rx = 1'b0;
      cycles(3);
      rx = 1'b1;
      cycles(3 * CPB);
      checks++;
      if (byte_count !== 6'd0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL glitch: bc=%0d fe=%b expected 0 0", byte_count, frame_err);
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_pulse: got %0d pulses expected 0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_stop_error;
      send_random(5);
      checks++;
      if (byte_count !== 6'(m_bytes.size())) begin
         errors++;
         $display("FAIL se_count_before: got %0d expected %0d", byte_count, m_bytes.size());
      end
      send_byte(8'($urandom), 1'b0);
      checks++;
      if (frame_err !== m_err || byte_count !== 6'd0) begin
         errors++;
         $display("FAIL se_error: fe=%b bc=%0d expected %b 0", frame_err, byte_count, m_err);
      end
      send_random(32);
      cycles(3);
      checks++;
      if (frame_err !== m_err) begin
         errors++;
         $display("FAIL se_err_clear: got %b expected %b", frame_err, m_err);
      end
      checks++;
      if (plaintext !== m_plain || key !== m_key) begin
         errors++;
         $display("FAIL se_data: pt=%h key=%h expected %h %h", plaintext, key, m_plain, m_key);
      end
      checks++;
      if (obs_q.size() != exp_q.size() || (obs_q.size() == 1 && obs_q[0] != exp_q[0])) begin
         errors++;
         $display("FAIL se_pulses: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_timeout;
      send_random(10);
      idle_gap(60);
      checks++;
      if (byte_count !== 6'(m_bytes.size())) begin
         errors++;
         $display("FAIL to_count: got %0d expected %0d", byte_count, m_bytes.size());
      end
      checks++;
      if (frame_err !== m_err) begin
         errors++;
         $display("FAIL to_err: got %b expected %b", frame_err, m_err);
      end
      send_random(32);
      cycles(3);
      checks++;
      if (plaintext !== m_plain || key !== m_key) begin
         errors++;
         $display("FAIL to_data: pt=%h key=%h expected %h %h", plaintext, key, m_plain, m_key);
      end
      checks++;
      if (obs_q.size() != exp_q.size() || (obs_q.size() == 1 && obs_q[0] != exp_q[0])) begin
         errors++;
         $display("FAIL to_pulses: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame;
      send_random(20);
      rx = 1'b0;
      cycles(35);
      reset = 1'b0;
      cycles(3);
      m_bytes.delete();
      m_plain = '0;
      m_key   = '0;
      m_err   = 1'b0;
      checks++;
      if (plaintext !== m_plain || key !== m_key) begin
         errors++;
         $display("FAIL rm_data: pt=%h key=%h expected 0", plaintext, key);
      end
      checks++;
      if (byte_count !== 6'd0 || frame_err !== 1'b0 || block_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_flags: bc=%0d fe=%b bv=%b expected 0 0 0",
                  byte_count, frame_err, block_valid);
      end
      rx    = 1'b1;
      reset = 1'b1;
      cycles(5);
      send_random(32);
      cycles(3);
      checks++;
      if (plaintext !== m_plain || key !== m_key) begin
         errors++;
         $display("FAIL rm_reload: pt=%h key=%h expected %h %h", plaintext, key, m_plain, m_key);
      end
      checks++;
      if (obs_q.size() != exp_q.size() || (obs_q.size() == 1 && obs_q[0] != exp_q[0])) begin
         errors++;
         $display("FAIL rm_pulses: got %0d pulses expected %0d", obs_q.size(), exp_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      send_random(32);
      send_random(32);
      cycles(3);
      checks++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d pulses expected 2", obs_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_q[i] != exp_q[i]) begin
               errors++;
               $display("FAIL b2b_time%0d: pulse at %0d expected %0d", i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (obs_q[1] - obs_q[0] != 32 * BYTE_CLKS) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d clk expected %0d", obs_q[1] - obs_q[0], 32 * BYTE_CLKS);
         end
      end
      checks++;
      if (plaintext !== m_plain || key !== m_key) begin
         errors++;
         $display("FAIL b2b_data: pt=%h key=%h expected %h %h", plaintext, key, m_plain, m_key);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b0;
      rx    = 1'b1;
      #1;
      test_reset();
      test_glitch();
      test_known_vector();
      test_stop_error();
      test_timeout();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
